// File: rtl/bus_dma_copy.sv
// Bus DMA copy engine: second initiator on the shared request bus. Each element is one read request then one write request.
// Optional DMA_CHECKSUM_EN adds a `checksum` output holding the running sum of every element read.
module bus_dma_copy #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [1:0]       xfer_size,
  input  logic             grant,
  output logic [31:0]      address,
  output logic             rw_req,
  output logic             rw,
  output logic [31:0]      write_data,
  output logic [1:0]       size,
  input  logic [31:0]      read_data,
  input  logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] count
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN} state_t;

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, dst_reg, data_reg;
  logic [LEN_W-1:0] len_reg, count_reg;
  logic [1:0]       size_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             held_reg, busy_reg, done_reg, error_reg;
  logic             req_phase, xfer_ok, xfer_timeout;
  logic [31:0]      step;

  assign req_phase    = (state_reg == RD) || (state_reg == WR);
  assign step         = 32'd1 << size_reg;
  // A completion in the expiry cycle wins over the timeout.
  assign xfer_ok      = rw_req && data_valid;
  assign xfer_timeout = rw_req && !data_valid && (timer_reg == TMR_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (length == '0) ? FIN : RD;
      RD: begin
        if (xfer_ok)           state_next = RGAP;
        else if (xfer_timeout) state_next = FIN;
      end
      RGAP: state_next = WR;
      WR: begin
        if (xfer_ok)           state_next = WGAP;
        else if (xfer_timeout) state_next = FIN;
      end
      WGAP:    state_next = (count_reg == len_reg) ? FIN : RD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A request may only begin while granted; once up it is held until completion or timeout.
  always_comb begin
    rw_req     = req_phase && (held_reg || grant);
    rw         = rw_req && (state_reg == WR);
    address    = '0;
    write_data = '0;
    size       = '0;
    if (rw_req) begin
      address = (state_reg == WR) ? dst_reg : src_reg;
      size    = size_reg;
      if (state_reg == WR) write_data = data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      data_reg  <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      size_reg  <= '0;
      timer_reg <= '0;
      held_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg   <= src_addr;
            dst_reg   <= dst_addr;
            len_reg   <= length;
            size_reg  <= (xfer_size == 2'b11) ? 2'b10 : xfer_size;
            count_reg <= '0;
            error_reg <= 1'b0;
            busy_reg  <= 1'b1;
            timer_reg <= '0;
            held_reg  <= 1'b0;
          end
        end
        RD, WR: begin
          if (xfer_ok || xfer_timeout) begin
            held_reg  <= 1'b0;
            timer_reg <= '0;
          end else if (rw_req) begin
            held_reg  <= 1'b1;
            timer_reg <= timer_reg + 1'b1;
          end
          if (xfer_timeout) error_reg <= 1'b1;
          if (xfer_ok && state_reg == RD) data_reg <= read_data;
          if (xfer_ok && state_reg == WR) begin
            count_reg <= count_reg + 1'b1;
            src_reg   <= src_reg + step;
            dst_reg   <= dst_reg + step;
          end
        end
        FIN: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign error = error_reg;
  assign count = count_reg;

`ifdef DMA_CHECKSUM_EN
  logic [31:0] checksum_reg, read_ext;

  always_comb begin
    case (size_reg)
      2'b00:   read_ext = {24'h0, read_data[7:0]};
      2'b01:   read_ext = {16'h0, read_data[15:0]};
      default: read_ext = read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                             checksum_reg <= '0;
    else if (state_reg == IDLE && start)   checksum_reg <= '0;
    else if (state_reg == RD && xfer_ok)   checksum_reg <= checksum_reg + read_ext;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_bus_dma_copy.sv
// Self-checking bench for bus_dma_copy: reference model fills expectation queues, a monitor checks bus and done events.
// Checksum checks are included when DMA_CHECKSUM_EN is defined.
module tb_bus_dma_copy;
  localparam int LEN_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0, reset = 1'b1, start = 1'b0, grant = 1'b0, data_valid = 1'b0;
  logic [31:0]      src_addr = '0, dst_addr = '0, read_data = '0;
  logic [LEN_W-1:0] length = '0;
  logic [1:0]       xfer_size = '0;
  logic [31:0]      address, write_data;
  logic             rw_req, rw, busy, done, error;
  logic [1:0]       size;
  logic [LEN_W-1:0] count;
`ifdef DMA_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  bus_dma_copy #(.TIMEOUT_CYCLES(TO), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .xfer_size(xfer_size), .grant(grant), .address(address), .rw_req(rw_req),
    .rw(rw), .write_data(write_data), .size(size), .read_data(read_data), .data_valid(data_valid),
    .busy(busy), .done(done), .error(error), .count(count)
`ifdef DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic rw; logic [1:0] size; logic [31:0] data; } bus_t;
  typedef struct { logic [LEN_W-1:0] cnt; logic err; logic [31:0] cks; } fin_t;

  bus_t        exp_bus[$];
  fin_t        exp_fin[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, errors = 0, done_cnt = 0;
  int          resp_lat = 2;
  bit          spur_en = 0, grant_rand = 0;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic logic [31:0] elem_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 32'd1;
      2'b01:   return 32'd2;
      default: return 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] s);
    case (s)
      2'b00:   return {24'h0, d[7:0]};
      2'b01:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_BAD0;
  endfunction

  // Reference model: the whole job as a list of bus transactions plus its final status.
  task automatic expect_job(input logic [31:0] s, input logic [31:0] d, input int n,
                            input logic [1:0] sz, input bit aborts);
    logic [1:0]  szn;
    logic [31:0] nb, cks;
    fin_t        f;
    szn = norm_size(sz);
    nb  = elem_bytes(szn);
    cks = '0;
    if (!aborts) begin
      for (int i = 0; i < n; i++) begin
        bus_t        r, w;
        logic [31:0] sa;
        sa = s + 32'(i) * nb;
        if (!mem.exists(sa)) mem[sa] = $urandom;
        r.addr = sa;                 r.rw = 1'b0; r.size = szn; r.data = '0;
        w.addr = d + 32'(i) * nb;    w.rw = 1'b1; w.size = szn; w.data = mem[sa];
        exp_bus.push_back(r);
        exp_bus.push_back(w);
        cks = cks + zext(mem[sa], szn);
      end
    end
    f.cnt = aborts ? '0 : LEN_W'(n);
    f.err = aborts;
    f.cks = cks;
    exp_fin.push_back(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n, input logic [1:0] sz);
    tick();
    src_addr = s; dst_addr = d; length = LEN_W'(n); xfer_size = sz; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0;
    bit ok;
    c0 = done_cnt;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt != c0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done_timeout got no done within %0d cycles, required a done pulse", tag, budget);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_at_done got busy=%b required 0", tag, busy);
      end
    end
    checks++;
    if (exp_bus.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got %0d unperformed transactions required 0", tag, exp_bus.size());
      exp_bus.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] ck;
    ck = '0;
`ifdef DMA_CHECKSUM_EN
    ck = checksum;
`endif
    checks++;
    if (address !== 0 || rw_req !== 0 || rw !== 0 || write_data !== 0 || size !== 0 ||
        busy !== 0 || done !== 0 || error !== 0 || count !== 0 || ck !== 0) begin
      errors++;
      $display("FAIL %s got addr=%h req=%b rw=%b wd=%h size=%0d busy=%b done=%b err=%b count=%0d cks=%h required all 0",
               tag, address, rw_req, rw, write_data, size, busy, done, error, count, ck);
    end
  endtask

  // Responder: answers resp_lat cycles into each request (never when resp_lat < 0).
  initial begin
    int age;
    age = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rw_req) begin
        if (resp_lat >= 0 && age == resp_lat) begin
          data_valid = 1'b1;
          read_data  = rw ? $urandom : mem_rd(address);
        end else begin
          data_valid = 1'b0;
          read_data  = $urandom;
        end
        age++;
      end else begin
        age        = 0;
        data_valid = spur_en && ($urandom_range(0, 3) == 0);
        read_data  = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (grant_rand) grant = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: one line per completed bus transaction and per done pulse.
  initial begin
    bit prev_req, prev_done, in_gap, gap_grant;
    int gap_len;
    prev_req = 0; prev_done = 0; in_gap = 0; gap_grant = 0; gap_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0; prev_done = 0; in_gap = 0;
        continue;
      end
      if (rw_req && !prev_req) begin
        checks++;
        if (!grant) begin
          errors++;
          $display("FAIL grant_rule got rw_req rising with grant=0 required no request");
        end
      end
      if (in_gap) begin
        if (rw_req) begin
          if (gap_len == 0 || gap_grant) begin
            checks++;
            if (gap_len != 1) begin
              errors++;
              $display("FAIL req_gap got %0d low cycles required 1", gap_len);
            end
          end
          in_gap = 0;
        end else begin
          gap_len++;
          if (!grant) gap_grant = 0;
        end
      end
      if (rw_req && data_valid) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected got addr=%h rw=%b required no transaction", address, rw);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          $display("txn addr=%h rw=%b size=%0d data=%h", address, rw, size, rw ? write_data : read_data);
          if (address !== e.addr || rw !== e.rw || size !== e.size || (e.rw && write_data !== e.data)) begin
            errors++;
            $display("FAIL bus_txn got addr=%h rw=%b size=%0d wd=%h required addr=%h rw=%b size=%0d wd=%h",
                     address, rw, size, write_data, e.addr, e.rw, e.size, e.data);
          end
        end
        in_gap = 1; gap_len = 0; gap_grant = 1;
      end
      if (done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width got done high 2 cycles running required 1-cycle pulse");
        end
        done_cnt++;
        in_gap = 0;
        checks++;
        if (exp_fin.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got done with count=%0d required no done", count);
        end else begin
          fin_t e;
          bit   cks_ok;
          e = exp_fin.pop_front();
          cks_ok = 1;
`ifdef DMA_CHECKSUM_EN
          cks_ok = (checksum === e.cks);
          $display("done count=%0d error=%b checksum=%h", count, error, checksum);
`else
          $display("done count=%0d error=%b", count, error);
`endif
          if (count !== e.cnt || error !== e.err || !cks_ok) begin
            errors++;
            $display("FAIL done_status got count=%0d error=%b required count=%0d error=%b cks=%h",
                     count, error, e.cnt, e.err, e.cks);
          end
        end
      end
      prev_req  = rw_req;
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish within time limit required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first, hi, c0;
    bit  saw, bad, ok;

    repeat (3) tick();
    @(negedge clk);
    check_zero("reset_state");
    tick();
    reset = 1'b0;

    // Word copy with a 2-cycle responder.
    grant = 1'b1; resp_lat = 2;
    expect_job(32'h1000, 32'h2000, 4, 2'b10, 0);
    pulse_start(32'h1000, 32'h2000, 4, 2'b10);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b required 1", busy); end
    wait_done("word", 300);

    // Byte copy; upper bits of each read word must not reach the checksum.
    mem.delete();
    mem[32'h3000] = 32'hAABBCC11;
    mem[32'h3001] = 32'h99887722;
    mem[32'h3002] = 32'h55443333;
    expect_job(32'h3000, 32'h4000, 3, 2'b00, 0);
    pulse_start(32'h3000, 32'h4000, 3, 2'b00);
    wait_done("byte", 300);
`ifdef DMA_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h66) begin errors++; $display("FAIL byte_checksum got %h required 00000066", checksum); end
`endif

    // Zero length: done two cycles after start, no request.
    expect_job(32'h0, 32'h0, 0, 2'b10, 0);
    tick();
    src_addr = 32'h100; dst_addr = 32'h200; length = '0; xfer_size = 2'b10; start = 1'b1;
    first = -1; saw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done && first < 0) first = k;
      if (rw_req) saw = 1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (first != 2 || saw) begin
      errors++;
      $display("FAIL zero_len got done at cycle %0d req_seen=%b required cycle 2 req_seen=0", first, saw);
    end

    // Grant withheld, then a responder that never answers.
    grant = 1'b0; resp_lat = -1;
    expect_job(32'h5000, 32'h6000, 3, 2'b10, 1);
    pulse_start(32'h5000, 32'h6000, 3, 2'b10);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rw_req) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL no_grant got rw_req=1 required 0 while grant=0"); end
    tick();
    grant = 1'b1;
    hi = 0; c0 = done_cnt;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rw_req) hi++;
      if (done_cnt != c0) break;
    end
    checks++;
    if (hi != TO || done_cnt == c0) begin
      errors++;
      $display("FAIL timeout got %0d request cycles done_seen=%b required %0d and done", hi, done_cnt != c0, TO);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got %b required 1", error); end

    // Reset while the second write is pending.
    resp_lat = 6;
    expect_job(32'h7000, 32'h8000, 2, 2'b10, 0);
    pulse_start(32'h7000, 32'h8000, 2, 2'b10);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rw_req && rw && count == 1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_setup got no second write required one within 200 cycles"); end
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_mid_write");
    exp_bus.delete();
    exp_fin.delete();
    tick();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    resp_lat = 1;
    expect_job(32'h7000, 32'h9000, 2, 2'b01, 0);
    pulse_start(32'h7000, 32'h9000, 2, 2'b01);
    wait_done("after_reset", 300);

    // Address wrap with size 11, plus an ignored start while busy.
    resp_lat = 2;
    expect_job(32'hFFFF_FFFC, 32'hA000, 2, 2'b11, 0);
    pulse_start(32'hFFFF_FFFC, 32'hA000, 2, 2'b11);
    repeat (3) tick();
    pulse_start(32'h5000, 32'h6000, 7, 2'b00);
    wait_done("wrap", 300);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rw_req !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored got busy=%b rw_req=%b required 0 0", busy, rw_req);
    end

    // Randomized jobs with random grant, latency and stray strobes.
    grant_rand = 1; spur_en = 1;
    for (int j = 0; j < 10; j++) begin
      logic [31:0] s, d;
      int          n;
      logic [1:0]  sz;
      s = $urandom; d = $urandom;
      n = $urandom_range(1, 6);
      sz = 2'($urandom_range(0, 3));
      resp_lat = $urandom_range(0, 3);
      expect_job(s, d, n, sz, 0);
      pulse_start(s, d, n, sz);
      wait_done("random", 600);
    end
    grant_rand = 0; spur_en = 0;
    tick();
    grant = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dma_copy.md
Name: bus_dma_copy

Overview:
- Second bus initiator that drives the shared memory/peripheral request bus (address, rw_req, rw, write_data, size, with read_data and data_valid returned).
- Copies LENGTH elements from a source address to a destination address: one read request, then one write request, per element.
- Sits next to the CPU on the same bus.
- Bus arbitration is outside this block; the `grant` input gates request issue.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles rw_req may stay high without data_valid before the transfer aborts.
- LEN_W, 16, width of the element-count input and counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; latches configuration when idle
- src_addr  input  32  first source byte address
- dst_addr  input  32  first destination byte address
- length  input  LEN_W  number of elements to copy
- xfer_size  input  2  element size: 00 byte, 01 half, 10 word, 11 treated as word
- grant  input  1  bus granted to this initiator; a request may start only while high
- address  output  32  bus address
- rw_req  output  1  bus request strobe
- rw  output  1  1 = write, 0 = read
- write_data  output  32  write data
- size  output  2  bus access size
- read_data  input  32  bus read data
- data_valid  input  1  responder completion strobe
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at end of transfer
- error  output  1  sticky timeout flag; cleared by the next accepted start
- count  output  LEN_W  elements completed

Behaviour:
- Clocking and reset: single clock `clk`. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE. A reset mid-transfer drops rw_req on the next edge and discards the transfer; no done pulse is produced.
- Bus handshake:
  - Initiator drives address, rw, size and write_data stable with rw_req=1.
  - It holds them until data_valid=1 is sampled.
  - read_data is captured in that same cycle.
  - rw_req then drops for exactly one cycle (GAP state) before the next request.
- States and transitions:
  - IDLE: start=1 latches src, dst, length, size (11 becomes 10). Clears count and error; sets busy=1.
    - length=0: go to FIN.
    - otherwise: go to RD.
  - start while busy is ignored.
  - RD: rw_req asserts only when grant=1, with address=src_cur, rw=0. On data_valid, latch read_data into a data register, then go to RGAP.
  - RGAP: rw_req=0 for one cycle, then go to WR.
  - WR: rw_req asserts only when grant=1, with address=dst_cur, rw=1, write_data=data register. On data_valid:
    - count+1;
    - src_cur and dst_cur each advance by 1<<size (mod 2^32, wrap allowed);
    - go to WGAP.
  - WGAP: rw_req=0 for one cycle. If count==length go to FIN, else go to RD.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Data alignment: sub-word data is passed unmodified in bits [31:0]. Lane placement is the responder's concern.
- grant rules:
  - A request does not start while grant=0.
  - Once rw_req=1, it is held regardless of grant until data_valid or timeout.
- Timeout:
  - A counter runs while rw_req=1.
  - When it reaches TIMEOUT_CYCLES with no data_valid: rw_req drops, error=1, go to FIN.
  - count holds the number of completed elements.
- Ignored strobe: data_valid arriving while rw_req=0 is ignored.
- Simultaneous events: data_valid in the same cycle the timeout expires counts as success.

Optional Feature:
- Macro: DMA_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` (32 bits): a modulo-2^32 sum of every element captured in RD, zero-extended to 32 bits according to size.
  - Cleared on accepted start and on reset.
  - Valid when done pulses.
- When undefined: the port and adder are absent, and behaviour is otherwise identical.

Test Plan:
- Word copy: start, src=0x1000, dst=0x2000, length=4, size=10, grant=1, responder data_valid 2 cycles after request.
  - Expect 4 reads at 0x1000..0x100C and 4 writes at 0x2000..0x200C with matching data.
  - Expect one low rw_req cycle between every request.
  - Expect count=4, then a single done pulse.
- Byte copy: length=3, size=00.
  - Expect addresses to step by 1 and count=3.
  - With DMA_CHECKSUM_EN and bytes 0x11, 0x22, 0x33, expect checksum=0x66.
- Zero length: start with length=0.
  - Expect no rw_req, done exactly 2 cycles after start, and count=0.
- Grant and timeout:
  - Hold grant=0 for 10 cycles: expect rw_req stays 0.
  - Then grant=1 with the responder never answering, TIMEOUT_CYCLES=16: expect rw_req high 16 cycles then low, error=1, done pulse, count=0.
- Reset mid-write: assert reset while WR has rw_req=1.
  - Expect every output 0 on the next edge, and no done pulse.
  - A new start after reset runs normally.
- Wrap and busy start: src=0xFFFFFFFC, length=2, size=10.
  - Expect the second read at 0x00000000.
  - A start pulse mid-transfer has no effect on the addresses or length in use.
